switch_input_ctrl: RTL and testbench

SWITCH_INPUT_CTRL -- requirements
Module: switch_input_ctrl

---
 rtl/switch_input_ctrl.sv | 118 +++++++++++
 tb/tb_switch_input_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/switch_input_ctrl.sv
// Switch input controller: synchronizes, debounces and reports
// groups of active-low switches over a small word-addressed bus.
module switch_input_ctrl #(
  parameter int NUM_BYTES = 8,
  parameter int DB_CYCLES = 100000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8*NUM_BYTES-1:0] sw_n,
  input  logic [3:0]             addr,
  input  logic                   we,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   irq
);

  localparam int NW = NUM_BYTES / 4;
  localparam int CW = $clog2(DB_CYCLES) + 1;
  localparam int NB = 8 * NUM_BYTES;
  localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);
  localparam logic [3:0] A_CTRL = 4'(2 * NW);

  if (NUM_BYTES % 4 != 0 || NUM_BYTES < 4 || NUM_BYTES > 16) begin : g_bad_nb
    $error("NUM_BYTES must be a multiple of 4 in 4..16");
  end
  if (DB_CYCLES < 1) begin : g_bad_db
    $error("DB_CYCLES must be at least 1");
  end

  logic [NB-1:0] r_s1;
  logic [NB-1:0] r_s2;
  logic [NB-1:0] r_stable;
  logic [NB-1:0] r_chg;
  logic [CW-1:0] r_cnt [NUM_BYTES];
  logic          r_irq_en;
  logic          r_irq;

  logic [NB-1:0] w_stable_nxt;
  logic [NB-1:0] w_set;
  logic [NB-1:0] w_clr;
  logic [CW-1:0] w_cnt_nxt [NUM_BYTES];
  logic          w_ctrl_we;

  // Per-byte debounce: restart on return to stable, commit on full count
  always_comb begin
    w_stable_nxt = r_stable;
    w_set        = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (~r_s2[8*i +: 8] == r_stable[8*i +: 8]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] == CMAX) begin
        w_stable_nxt[8*i +: 8] = ~r_s2[8*i +: 8];
        w_set[8*i +: 8]        = ~r_s2[8*i +: 8] ^ r_stable[8*i +: 8];
        w_cnt_nxt[i]           = '0;
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + CW'(1);
      end
    end
  end

  // Bus write decode: W1C mask for change words, control load strobe
  always_comb begin
    w_clr     = '0;
    w_ctrl_we = we && (addr == A_CTRL);
    for (int j = 0; j < NW; j++) begin
      if (we && addr == 4'(NW + j)) begin
        w_clr[32*j +: 32] = wdata;
      end
    end
  end

  // Bus read mux; unmapped addresses read zero
  always_comb begin
    rdata = '0;
    for (int j = 0; j < NW; j++) begin
      if (addr == 4'(j)) begin
        rdata = r_stable[32*j +: 32];
      end
      if (addr == 4'(NW + j)) begin
        rdata = r_chg[32*j +: 32];
      end
    end
    if (addr == A_CTRL) begin
      rdata = {31'b0, r_irq_en};
    end
  end

  // State update; a new change beats a same-cycle W1C clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1     <= '1;
      r_s2     <= '1;
      r_stable <= '0;
      r_chg    <= '0;
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
      for (int i = 0; i < NUM_BYTES; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1     <= sw_n;
      r_s2     <= r_s1;
      r_stable <= w_stable_nxt;
      r_chg    <= (r_chg & ~w_clr) | w_set;
      r_irq    <= r_irq_en & (|r_chg);
      if (w_ctrl_we) begin
        r_irq_en <= wdata[0];
      end
      for (int i = 0; i < NUM_BYTES; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign irq = r_irq;

endmodule

// File: tb/tb_switch_input_ctrl.sv
// Directed bench for switch_input_ctrl with NUM_BYTES=8, DB_CYCLES=4.
// Expected values are queued when stimulus is applied, popped at check.
module tb_switch_input_ctrl;

  logic        clk;
  logic        reset;
  logic [63:0] sw_n;
  logic [3:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  switch_input_ctrl #(
    .NUM_BYTES(8),
    .DB_CYCLES(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sw_n  (sw_n),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic compare(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, observed %h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      checks++;
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic chk_rd(input logic [3:0] a, input logic [31:0] v,
                        input string tag);
    push(v);
    addr = a;
    #1;
    compare(tag, rdata);
  endtask

  task automatic chk_irq(input logic v, input string tag);
    push({31'b0, v});
    #1;
    compare(tag, {31'b0, irq});
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick(1);
    we    = 1'b0;
    wdata = '0;
  endtask

  initial begin
    reset = 1'b1;
    sw_n  = '1;
    addr  = '0;
    we    = 1'b0;
    wdata = '0;
    @(negedge clk);
    tick(2);
    for (int a = 0; a < 5; a++) chk_rd(4'(a), 32'h0, "reset_rd");
    chk_irq(1'b0, "reset_irq");
    reset = 1'b0;

    for (int c = 0; c < 100; c++) begin
      tick(1);
      chk_irq(1'b0, "idle_irq");
    end
    for (int a = 0; a < 5; a++) chk_rd(4'(a), 32'h0, "idle_rd");

    sw_n[7:0] = 8'hFE;
    tick(5);
    chk_rd(4'd0, 32'h0, "lat_edge5");
    tick(1);
    chk_rd(4'd0, 32'h1, "lat_edge6");
    chk_rd(4'd2, 32'h1, "lat_chg");

    wr(4'd2, 32'hFFFF_FFFF);
    chk_rd(4'd2, 32'h0, "w1c_all");

    sw_n = '1;
    sw_n[47:40] = 8'hA5;
    tick(10);
    chk_rd(4'd1, 32'h0000_5A00, "b5_data");
    chk_rd(4'd3, 32'h0000_5A00, "b5_chg");
    chk_rd(4'd0, 32'h0, "b0_release");
    chk_rd(4'd2, 32'h1, "b0_release_chg");

    wr(4'd2, 32'hFFFF_FFFF);
    wr(4'd3, 32'h0000_0200);
    chk_rd(4'd3, 32'h0000_5800, "w1c_partial");
    wr(4'd3, 32'hFFFF_FFFF);
    chk_rd(4'd3, 32'h0, "w1c_word1");

    wr(4'd0, 32'hFFFF_FFFF);
    chk_rd(4'd0, 32'h0, "ro_data0");
    wr(4'd1, 32'h0);
    chk_rd(4'd1, 32'h0000_5A00, "ro_data1");
    wr(4'd5, 32'hFFFF_FFFF);
    chk_rd(4'd5, 32'h0, "unmapped5");
    chk_rd(4'd15, 32'h0, "unmapped15");
    chk_rd(4'd4, 32'h0, "ctrl_untouched");

    for (int c = 0; c < 20; c++) begin
      sw_n[7:0] = ((c / 2) % 2 == 0) ? 8'hFE : 8'hFF;
      tick(1);
      chk_rd(4'd0, 32'h0, "bounce_data");
    end
    sw_n[7:0] = 8'hFF;
    tick(10);
    chk_rd(4'd0, 32'h0, "bounce_final");
    chk_rd(4'd2, 32'h0, "bounce_chg");
    chk_irq(1'b0, "bounce_irq");

    sw_n[7:0] = 8'hFE;
    tick(6);
    chk_rd(4'd2, 32'h1, "irq_chg_pend");
    wr(4'd4, 32'h1);
    chk_rd(4'd4, 32'h1, "ctrl_en");
    chk_irq(1'b0, "irq_reg_delay");
    tick(1);
    chk_irq(1'b1, "irq_assert");
    wr(4'd2, 32'h1);
    chk_rd(4'd2, 32'h0, "w1c_bit0");
    chk_irq(1'b1, "irq_hold_1cyc");
    tick(1);
    chk_irq(1'b0, "irq_clear");

    sw_n[7:0] = 8'hFF;
    tick(5);
    wr(4'd2, 32'h1);
    chk_rd(4'd0, 32'h0, "race_data");
    chk_rd(4'd2, 32'h1, "race_set_wins");
    tick(1);
    chk_irq(1'b1, "race_irq");
    chk_rd(4'd2, 32'h1, "race_chg_hold");

    sw_n[7:0] = 8'hFE;
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk_rd(4'd0, 32'h0, "rst_data");
    chk_rd(4'd2, 32'h0, "rst_chg");
    chk_rd(4'd4, 32'h0, "rst_ctrl");
    chk_irq(1'b0, "rst_irq");
    tick(5);
    chk_rd(4'd0, 32'h0, "rst_lat5");
    tick(1);
    chk_rd(4'd0, 32'h1, "rst_lat6");
    chk_rd(4'd2, 32'h1, "rst_on_chg");
    chk_rd(4'd3, 32'h0000_5A00, "rst_b5_chg");
    chk_irq(1'b0, "rst_irq_dis");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
